// File: rtl/scoreboard_hazard_if.sv
// ID-stage request and hazard-control response bundle for the scoreboard hazard unit.
interface scoreboard_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic                  id_rs1_used;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_early_read;
  logic                  flush;
  logic                  ext_stall;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_nop_signal;
  logic [PERF_W-1:0]     stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, id_early_read, flush, ext_stall,
    input  pc_write, if_id_write, id_nop_signal, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
           id_reg_write, id_mem_read, id_early_read, flush, ext_stall,
    output pc_write, if_id_write, id_nop_signal, stall_cycles
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based ID hazard detector: per-register countdowns of pending writes drive
// PC/IF-ID stalls and ID bubbles for load-use and early-read hazards.
module scoreboard_hazard_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] fwd_init_i,
  input  logic [CNT_W-1:0] wb_init_i,
  output logic [CNT_W-1:0] fwd_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o
);
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  // A fresh issue replaces the old entry outright; otherwise count down to zero.
  always_comb begin
    fwd_cnt_d = fwd_cnt_q;
    wb_cnt_d  = wb_cnt_q;
    if (wr_i) begin
      fwd_cnt_d = fwd_init_i;
      wb_cnt_d  = wb_init_i;
    end else if (!hold_i) begin
      if (fwd_cnt_q != '0) fwd_cnt_d = fwd_cnt_q - CNT_W'(1);
      if (wb_cnt_q != '0)  wb_cnt_d  = wb_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_cnt_q <= '0;
      wb_cnt_q  <= '0;
    end else begin
      fwd_cnt_q <= fwd_cnt_d;
      wb_cnt_q  <= wb_cnt_d;
    end
  end

  assign fwd_cnt_o = fwd_cnt_q;
  assign wb_cnt_o  = wb_cnt_q;
endmodule

module scoreboard_hazard_unit #(
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int ID_READ_STALL  = 2,
  parameter int CNT_W          = 2,
  parameter int PERF_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  scoreboard_hazard_if.slave sb
);
  localparam logic [CNT_W-1:0] LU_INIT = CNT_W'(LOAD_USE_STALL);
  localparam logic [CNT_W-1:0] WB_INIT = CNT_W'(ID_READ_STALL);

  logic [NUM_REGS-1:0][CNT_W-1:0] fwd_cnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] wb_cnt;
  logic [NUM_REGS-1:0]            wr_sel;
  logic [CNT_W-1:0]               fwd_init;
  logic                           busy1, busy2, hazard, issue;
  logic [PERF_W-1:0]              stall_cnt_q, stall_cnt_d;

  // Early-read consumers wait for write-through at WB; others only for the forward window.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (sb.id_rs1 != '0 && int'(sb.id_rs1) < NUM_REGS)
      busy1 = sb.id_early_read ? (wb_cnt[sb.id_rs1] != '0) : (fwd_cnt[sb.id_rs1] != '0);
    if (sb.id_rs2 != '0 && int'(sb.id_rs2) < NUM_REGS)
      busy2 = sb.id_early_read ? (wb_cnt[sb.id_rs2] != '0) : (fwd_cnt[sb.id_rs2] != '0);
  end

  assign hazard = sb.id_valid && !sb.flush &&
                  ((sb.id_rs1_used && busy1) || (sb.id_rs2_used && busy2));
  assign issue  = sb.id_valid && !hazard && !sb.flush && !sb.ext_stall &&
                  sb.id_reg_write && (sb.id_rd != '0);
  assign fwd_init = sb.id_mem_read ? LU_INIT : '0;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++)
      wr_sel[r] = issue && (int'(sb.id_rd) == r);
  end

  // Entry 0 never sees a write (issue excludes rd==0), so x0 stays idle.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    scoreboard_hazard_entry #(.CNT_W(CNT_W)) u_entry (
      .clk        (clk),
      .reset      (reset),
      .hold_i     (sb.ext_stall),
      .wr_i       (wr_sel[r]),
      .fwd_init_i (fwd_init),
      .wb_init_i  (WB_INIT),
      .fwd_cnt_o  (fwd_cnt[r]),
      .wb_cnt_o   (wb_cnt[r])
    );
  end

  assign sb.pc_write      = !reset && !hazard;
  assign sb.if_id_write   = !reset && !hazard;
  assign sb.id_nop_signal = reset || hazard;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !sb.ext_stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign sb.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit; a second PERF_W=4 instance mirrors the stimulus.
module tb_scoreboard_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   exp_sc = 0;

  localparam logic [2:0] GO    = 3'b110;
  localparam logic [2:0] STALL = 3'b001;

  scoreboard_hazard_if #(.REG_ADDR_W(5), .PERF_W(32)) bus ();
  scoreboard_hazard_if #(.REG_ADDR_W(5), .PERF_W(4))  bus4 ();

  assign bus4.id_valid      = bus.id_valid;
  assign bus4.id_rs1        = bus.id_rs1;
  assign bus4.id_rs1_used   = bus.id_rs1_used;
  assign bus4.id_rs2        = bus.id_rs2;
  assign bus4.id_rs2_used   = bus.id_rs2_used;
  assign bus4.id_rd         = bus.id_rd;
  assign bus4.id_reg_write  = bus.id_reg_write;
  assign bus4.id_mem_read   = bus.id_mem_read;
  assign bus4.id_early_read = bus.id_early_read;
  assign bus4.flush         = bus.flush;
  assign bus4.ext_stall     = bus.ext_stall;

  scoreboard_hazard_unit #(.PERF_W(32)) dut (.clk(clk), .reset(reset), .sb(bus));
  scoreboard_hazard_unit #(.PERF_W(4))  dut4 (.clk(clk), .reset(reset), .sb(bus4));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {29'd0, bus.pc_write, bus.if_id_write, bus.id_nop_signal};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic er);
    bus.id_valid = 1'b1;  bus.id_rs1 = rs1; bus.id_rs1_used = u1;
    bus.id_rs2 = rs2;     bus.id_rs2_used = u2; bus.id_rd = rd;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_early_read = er;
    bus.flush = 1'b0;     bus.ext_stall = 1'b0;
    #1;
  endtask

  task automatic idle();
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    bus.id_valid = 1'b0;
    #1;
  endtask

  task automatic gap();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) tick();
    chk("reset_ctl", ctl(), STALL);
    chk("reset_sc", bus.stall_cycles, 0);
    chk("reset_sc4", 32'(bus4.stall_cycles), 0);
    reset = 1'b0; #1;
    chk("idle_ctl", ctl(), GO);

    // load-use: lw x5 ; add x6,x5,x1
    drive(5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0); chk("lu_prod", ctl(), GO); tick();
    drive(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0); chk("lu_t1", ctl(), STALL); tick(); exp_sc++;
    chk("lu_t2", ctl(), GO); tick();
    idle(); chk("lu_sc", bus.stall_cycles, exp_sc);
    gap();

    // ALU producer forwards with no stall
    drive(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0); tick();
    drive(5'd5, 1, 5'd5, 1, 5'd7, 1, 0, 0); chk("alu_t1", ctl(), GO); tick();
    idle(); chk("alu_sc", bus.stall_cycles, exp_sc);
    gap();

    // early read: addi x17 ; ecall
    drive(5'd0, 1, 5'd0, 0, 5'd17, 1, 0, 0); tick();
    drive(5'd17, 1, 5'd0, 0, 5'd0, 0, 0, 1); chk("er_t1", ctl(), STALL); tick(); exp_sc++;
    chk("er_t2", ctl(), STALL); tick(); exp_sc++;
    chk("er_t3", ctl(), GO); tick();
    idle(); chk("er_sc", bus.stall_cycles, exp_sc);
    gap();

    // ext_stall freezes countdown and the perf counter
    drive(5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0); tick();
    drive(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0); bus.ext_stall = 1'b1; #1;
    chk("ext_ctl", ctl(), STALL);
    repeat (4) tick();
    chk("ext_hold_sc", bus.stall_cycles, exp_sc);
    bus.ext_stall = 1'b0; #1;
    chk("ext_rel", ctl(), STALL); tick(); exp_sc++;
    chk("ext_go", ctl(), GO); tick();
    idle(); chk("ext_sc", bus.stall_cycles, exp_sc);
    gap();

    // ext_stall blocks issue of a ready producer
    drive(5'd0, 0, 5'd0, 0, 5'd9, 1, 1, 0); bus.ext_stall = 1'b1; #1;
    repeat (2) tick();
    idle();
    drive(5'd9, 1, 5'd0, 0, 5'd0, 0, 0, 1); chk("ext_noissue", ctl(), GO); tick();
    gap();

    // x0 is never busy
    drive(5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0); tick();
    drive(5'd0, 1, 5'd0, 1, 5'd0, 0, 0, 1); chk("x0_read", ctl(), GO); tick();
    gap();

    // flushed consumer neither stalls nor issues
    drive(5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0); tick();
    drive(5'd5, 1, 5'd0, 0, 5'd8, 1, 1, 0); bus.flush = 1'b1; #1;
    chk("flush_ctl", ctl(), GO); tick();
    drive(5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 1); chk("flush_noissue", ctl(), GO); tick();
    gap();

    // rs2 path and its used-gating
    drive(5'd0, 0, 5'd0, 0, 5'd10, 1, 1, 0); tick();
    drive(5'd3, 1, 5'd10, 0, 5'd0, 0, 0, 0); chk("rs2_unused", ctl(), GO); tick();
    gap();
    drive(5'd0, 0, 5'd0, 0, 5'd11, 1, 1, 0); tick();
    drive(5'd3, 1, 5'd11, 1, 5'd0, 0, 0, 0); chk("rs2_used", ctl(), STALL); tick(); exp_sc++;
    chk("rs2_go", ctl(), GO); tick();
    gap();

    // lw x5 ; lw x5,0(x5) ; add x6,x5 -- newest producer wins
    drive(5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0); tick();
    drive(5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0); chk("self_t1", ctl(), STALL); tick(); exp_sc++;
    chk("self_t2", ctl(), GO); tick();
    drive(5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0); chk("self_t3", ctl(), STALL); tick(); exp_sc++;
    chk("self_t4", ctl(), GO); tick();
    idle(); chk("self_sc", bus.stall_cycles, exp_sc);
    gap();

    // drive the 4-bit counter past saturation
    for (int k = 0; k < 10; k++) begin
      drive(5'd0, 1, 5'd0, 0, 5'd17, 1, 0, 0); tick();
      drive(5'd17, 1, 5'd0, 0, 5'd0, 0, 0, 1); tick(); exp_sc++;
      tick(); exp_sc++;
      chk("sat_round_go", ctl(), GO); tick();
    end
    idle();
    chk("sat_sc32", bus.stall_cycles, exp_sc);
    chk("sat_sc4", 32'(bus4.stall_cycles), 32'd15);

    // reset in the middle of a load-use stall
    drive(5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0); tick();
    drive(5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0); chk("rst_pre", ctl(), STALL);
    reset = 1'b1; #1;
    chk("rst_mid_ctl", ctl(), STALL); tick();
    reset = 1'b0; #1;
    chk("rst_after_ctl", ctl(), GO);
    chk("rst_after_sc", bus.stall_cycles, 0);
    tick();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
